// File: rtl/apb4_master_bridge.sv
// APB4 initiator: turns one valid/ready request into a SETUP/ACCESS transfer and returns
// the slave's read data and status on a valid/ready response, with an optional ACCESS timeout.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter holds the number of ACCESS cycles already spent without pready; the
    // cycle that would make it reach TIMEOUT_CYCLES aborts instead.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        paddr     <= req_addr;
                        pwrite    <= req_write;
                        pwdata    <= req_wdata;
                        pstrb     <= req_write ? req_strb : '0;
                        pprot     <= req_prot;
                        psel      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready takes priority over a timeout landing on the same cycle
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= RESP;
                    end else if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// Bench for apb4_master_bridge: the bench plays both requester and APB slave, cycle by cycle,
// and predicts each transfer's outcome from its chosen wait states, error and the memory model.
module tb_apb4_master_bridge;
    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_addr, req_prot;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr, pprot;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    logic [31:0] mem [8];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 pclk = ~pclk;

    apb4_master_bridge #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_fields(input string ph, input logic w, input logic [2:0] a,
                              input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
        chk({ph, "_paddr"}, paddr, a);
        chk({ph, "_pwrite"}, pwrite, w);
        chk({ph, "_pstrb"}, pstrb, w ? st : 4'h0);
        chk({ph, "_pprot"}, pprot, pr);
        if (w) chk({ph, "_pwdata"}, pwdata, wd);
    endtask

    // One complete transfer. Slave asserts pready on ACCESS cycle waits+1; rdly = cycles
    // rsp_ready is held low while a stray request is presented.
    task automatic txn(input logic w, input logic [2:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr,
                       input int waits, input logic err, input int rdly);
        logic        exp_to, exp_err;
        logic [31:0] exp_rd;
        int          acc, lim;
        exp_to  = (waits >= TO);
        exp_err = exp_to || err;
        exp_rd  = (w || exp_to) ? 32'h0 : mem[a];

        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        req_strb  = st;   req_prot  = pr;
        lim = 0;
        while (!req_ready && lim < 10) begin @(negedge pclk); lim++; end
        chk("req_ready_idle", req_ready, 1);
        @(negedge pclk);
        req_valid = 1'b0;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk_fields("setup", w, a, wd, st, pr);
        @(negedge pclk);
        acc = 0;
        while (psel && penable && acc < 40) begin
            acc++;
            chk_fields("access", w, a, wd, st, pr);
            pready  = (acc == waits + 1);
            pslverr = pready ? err : 1'($urandom_range(0, 1));
            prdata  = pready ? mem[a] : $urandom;
            @(negedge pclk);
        end
        pready = 1'b0; pslverr = 1'b0;
        chk("access_cycles", acc, exp_to ? TO : waits + 1);
        if (w && !exp_to && !err)
            for (int b = 0; b < 4; b++) if (st[b]) mem[a][8*b +: 8] = wd[8*b +: 8];

        for (int d = 0; d < rdly; d++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 3'($urandom);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_psel", psel, 0);
            @(negedge pclk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_psel", psel, 0);
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'h1111_1111 * i;
        presetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #22;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(negedge pclk); presetn = 1'b1;
        @(negedge pclk);
        chk("rel_req_ready", req_ready, 1);

        // directed cases
        txn(1, 3'h0, 32'hDEADBEEF, 4'hF, 3'h2, 0, 0, 0);
        txn(0, 3'h0, 32'h0, 4'hF, 3'h0, 0, 0, 0);
        chk("mem0", mem[0], 32'hDEADBEEF);
        txn(1, 3'h4, 32'hCAFEBABE, 4'hF, 3'h1, 3, 0, 0);
        txn(0, 3'h4, 32'h0, 4'h0, 3'h1, 3, 0, 0);
        txn(0, 3'h2, 32'h0, 4'h0, 3'h0, 2, 1, 0);
        txn(0, 3'h3, 32'h0, 4'h0, 3'h0, 20, 0, 0);
        txn(1, 3'h3, 32'h12345678, 4'h5, 3'h0, 16, 0, 0);
        txn(0, 3'h3, 32'h0, 4'h0, 3'h7, 15, 0, 0);
        txn(0, 3'h4, 32'h0, 4'h0, 3'h0, 0, 0, 5);

        // reset while in ACCESS
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'h6; req_wdata = 32'hBAD0BAD0;
        req_strb = 4'hF; req_prot = 3'h0;
        @(negedge pclk); req_valid = 1'b0;
        @(negedge pclk);
        chk("pre_rst_penable", penable, 1);
        #2 presetn = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge pclk); presetn = 1'b1;
        @(negedge pclk);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_req_ready", req_ready, 1);
        txn(0, 3'h6, 32'h0, 4'h0, 3'h0, 1, 0, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            int wt;
            wt = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
            txn(1'($urandom_range(0, 1)), 3'($urandom), $urandom, 4'($urandom), 3'($urandom),
                wt, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
